// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder, LSB-first, WIDTH cycles per addition.
// A three-state controller sequences the operand/result shift registers.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             w_fa_s;
  logic             w_fa_c;
  logic             w_last;

  full_adder u_fa (
    .i_a (r_a[0]),
    .i_b (r_b[0]),
    .i_c (r_carry),
    .o_s (w_fa_s),
    .o_c (w_fa_c)
  );

  // The bit being added this cycle is the final one; the counter reaches
  // WIDTH on the same edge, which still fits in CW bits.
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: defaults first so every path assigns w_next and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // NOTE: every datapath register is cleared by reset, so an aborted
  // addition leaves nothing behind for the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= Cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_res   <= {w_fa_s, r_res[WIDTH-1:1]};
          r_carry <= w_fa_c;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_cnt   <= r_cnt + 1'b1;
          // Result register is one bit short here, so splice in the last bit.
          if (w_last) begin
            r_sum  <= {w_fa_s, r_res[WIDTH-1:1]};
            r_cout <= w_fa_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign Sum  = r_sum;
  assign Cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized checks of serial_adder_ctrl at WIDTH=8 against
// an arithmetic reference ({Cout,Sum} = A+B+Cin, fixed latency of WIDTH).

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         Cout;

  int n_checks = 0;
  int n_errors = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result of one addition, straight from the arithmetic definition.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // Present operands for one cycle from IDLE, scramble inputs while busy,
  // and check busy/done timing and the result against the reference.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input string tag);
    logic [W:0] exp;
    exp = ref_add(a, b, c);
    @(negedge clk);
    start = 1'b1; A = a; B = b; Cin = c;
    @(negedge clk);
    start = 1'b0; A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_nodone"}, 32'(done), 32'd0);
      @(negedge clk);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_sum"}, 32'(Sum), 32'(exp[W-1:0]));
    check({tag, "_cout"}, 32'(Cout), 32'(exp[W]));
    @(negedge clk);
    check({tag, "_pulse1"}, 32'(done), 32'd0);
    check({tag, "_hold_sum"}, 32'(Sum), 32'(exp[W-1:0]));
  endtask

  initial begin
    int n_done;
    int last_done;
    logic [W:0] exp;

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(Sum), 32'd0);
    check("rst_cout", 32'(Cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h00, 8'h00, 1'b0, "zero");
    run_op(8'hFF, 8'h01, 1'b0, "ff_01");
    run_op(8'hFF, 8'hFF, 1'b1, "ff_ff_c");

    // Start re-pulsed with new operands while the first addition is in flight.
    @(negedge clk);
    start = 1'b1; A = 8'h5A; B = 8'hA5; Cin = 1'b0;
    n_done = 0;
    for (int i = 1; i <= W + 4; i++) begin
      @(negedge clk);
      if (i >= 2 && i <= 5) begin start = 1'b1; A = 8'h01; B = 8'h01; end
      else start = 1'b0;
      if (done) begin
        n_done++;
        check("inflight_sum", 32'(Sum), 32'hFF);
        check("inflight_cout", 32'(Cout), 32'd0);
      end
    end
    check("inflight_ndone", 32'(n_done), 32'd1);

    // Asynchronous reset four cycles into RUN.
    @(negedge clk);
    start = 1'b1; A = 8'h77; B = 8'h11; Cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(Sum), 32'd0);
    check("abort_cout", 32'(Cout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_nodone", 32'(n_done), 32'd0);
    run_op(8'h3C, 8'hC3, 1'b1, "post_rst");

    // Start held high: one acceptance every W+2 cycles.
    @(negedge clk);
    start = 1'b1; A = 8'h10; B = 8'h20; Cin = 1'b0;
    n_done = 0;
    last_done = -1;
    for (int cyc = 0; cyc < 5 * (W + 2); cyc++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        check("cont_sum", 32'(Sum), 32'h30);
        check("cont_cout", 32'(Cout), 32'd0);
        if (last_done >= 0) check("cont_period", 32'(cyc - last_done), 32'(W + 2));
        last_done = cyc;
      end
    end
    check("cont_ndone", 32'(n_done), 32'd5);
    start = 1'b0;
    repeat (W + 3) @(negedge clk);

    // Randomized sweep with Cin alternating plus random bias.
    for (int i = 0; i < 256; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom) ^ 1'(i);
      if (i == 0) begin ra = 8'hFF; rb = 8'hFF; rc = 1'b1; end
      run_op(ra, rb, rc, "rand");
    end

    exp = ref_add(8'h80, 8'h80, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, "msb_carry");
    check("msb_carry_ref", 32'(Cout), 32'(exp[W]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
